// File: rtl/register_file_pkg.sv
// register_file_pkg: shared sizes and clear-engine state encoding
package register_file_pkg;
  localparam int REG_COUNT = 32;
  localparam int ADDR_W = 5;
  typedef enum logic {S_IDLE, S_CLEARING} clr_state_t;
endpackage

// File: rtl/register_file_decoder.sv
// decoder_5_to_32: one-hot write strobe from a 5-bit register index
module decoder_5_to_32
  import register_file_pkg::*;
(
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 en,
  output logic [REG_COUNT-1:0] sel
);
  // one-hot strobe, all low when disabled
  always_comb sel = en ? REG_COUNT'(1) << addr : '0;
endmodule

// File: rtl/register_file.sv
// register_file: 31xN storage with x0 tied to zero, two async read ports and a sequenced clear engine
module register_file
  import register_file_pkg::*;
#(
  parameter int N = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_ena,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [N-1:0]      wr_data,
  input  logic [ADDR_W-1:0] rd_addr0,
  output logic [N-1:0]      rd_data0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [N-1:0]      rd_data1,
  input  logic              clear,
  output logic              busy
);
  logic [N-1:0] regs [1:REG_COUNT-1];
  clr_state_t state;
  logic [ADDR_W-1:0] clr_idx;
  logic [REG_COUNT-1:0] wr_sel;
  logic unused_sel0;
  decoder_5_to_32 u_dec (
    .addr(wr_addr),
    .en  (wr_ena && state == S_IDLE),
    .sel (wr_sel)
  );
  assign unused_sel0 = wr_sel[0];
  assign busy = state == S_CLEARING;
  // clear sequencer: walks clr_idx from 1 to 31, then returns to idle
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      clr_idx <= '0;
    end else if (state == S_CLEARING) begin
      clr_idx <= clr_idx + 5'd1;
      if (clr_idx == ADDR_W'(REG_COUNT - 1)) state <= S_IDLE;
    end else if (clear) begin
      state <= S_CLEARING;
      clr_idx <= 5'd1;
    end
  // storage: reset and clear zeroing win over the write strobe
  always_ff @(posedge clk)
    for (int i = 1; i < REG_COUNT; i++)
      if (rst || (busy && clr_idx == ADDR_W'(i))) regs[i] <= '0;
      else if (wr_sel[i]) regs[i] <= wr_data;
  // read ports: x0 reads as zero, no forwarding from the write port
  always_comb begin
    rd_data0 = rd_addr0 == '0 ? '0 : regs[rd_addr0];
    rd_data1 = rd_addr1 == '0 ? '0 : regs[rd_addr1];
  end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed vector table plus clear/reset sequences for register_file
module tb_register_file;
  logic clk = 0, rst = 1, wr_ena = 0, clear = 0, busy;
  logic [4:0] wr_addr = 0, rd_addr0 = 0, rd_addr1 = 0;
  logic [31:0] wr_data = 0, rd_data0, rd_data1;
  int tests = 0, fails = 0;

  register_file dut (
    .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr0(rd_addr0), .rd_data0(rd_data0), .rd_addr1(rd_addr1), .rd_data1(rd_data1),
    .clear(clear), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic we;
    logic [4:0] wa;
    logic [31:0] wd;
    logic [4:0] ra0, ra1;
    logic [31:0] e0, e1;
  } vec_t;
  vec_t vecs [9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
    rd_addr0 = a;
    rd_addr1 = a;
    #1;
    check({name, "_p0"}, rd_data0, exp);
    check({name, "_p1"}, rd_data1, exp);
  endtask

  task automatic fill();
    wr_ena = 1;
    for (int i = 1; i < 32; i++) begin
      wr_addr = 5'(i);
      wr_data = 32'(i);
      step();
    end
    wr_ena = 0;
  endtask

  initial begin
    int cnt;
    vecs[0] = '{1, 5, 32'hDEADBEEF, 5, 5, 0, 0};
    vecs[1] = '{0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1, 0, 32'h12345678, 0, 5, 0, 32'hDEADBEEF};
    vecs[3] = '{0, 0, 0, 0, 0, 0, 0};
    vecs[4] = '{1, 31, 32'hFFFFFFFF, 31, 5, 0, 32'hDEADBEEF};
    vecs[5] = '{1, 1, 32'h1, 31, 1, 32'hFFFFFFFF, 0};
    vecs[6] = '{0, 0, 0, 1, 31, 32'h1, 32'hFFFFFFFF};
    vecs[7] = '{1, 5, 32'hCAFEF00D, 5, 0, 32'hDEADBEEF, 0};
    vecs[8] = '{0, 0, 0, 5, 5, 32'hCAFEF00D, 32'hCAFEF00D};

    step();
    step();
    rst = 0;
    check("reset_busy", 32'(busy), 0);
    for (int i = 0; i < 32; i++) begin
      rd_addr0 = 5'(i);
      rd_addr1 = 5'(31 - i);
      #1;
      check("reset_rd0", rd_data0, 0);
      check("reset_rd1", rd_data1, 0);
    end

    for (int v = 0; v < 9; v++) begin
      wr_ena = vecs[v].we;
      wr_addr = vecs[v].wa;
      wr_data = vecs[v].wd;
      rd_addr0 = vecs[v].ra0;
      rd_addr1 = vecs[v].ra1;
      #1;
      check($sformatf("vec%0d_rd0", v), rd_data0, vecs[v].e0);
      check($sformatf("vec%0d_rd1", v), rd_data1, vecs[v].e1);
      step();
    end
    wr_ena = 0;

    fill();
    rd("fill_x11", 11, 11);
    clear = 1;
    step();
    wr_ena = 1;
    wr_addr = 7;
    wr_data = 32'hA5A5A5A5;
    cnt = 0;
    while (busy && cnt < 40) begin
      if (cnt == 10) begin
        rd("mid_x10", 10, 0);
        rd("mid_x11", 11, 11);
      end
      if (cnt == 20) clear = 0;
      step();
      cnt++;
    end
    wr_ena = 0;
    clear = 0;
    check("busy_cycles", 32'(cnt), 31);
    check("busy_after", 32'(busy), 0);
    for (int i = 0; i < 32; i++) rd("cleared", 5'(i), 0);

    wr_ena = 1;
    wr_addr = 7;
    wr_data = 32'hA5A5A5A5;
    step();
    wr_ena = 0;
    rd("post_clear_x7", 7, 32'hA5A5A5A5);
    check("post_clear_idle", 32'(busy), 0);

    fill();
    clear = 1;
    step();
    clear = 0;
    for (int i = 0; i < 5; i++) step();
    check("pre_rst_busy", 32'(busy), 1);
    rd("pre_rst_x20", 20, 20);
    rd("pre_rst_x3", 3, 0);
    rst = 1;
    wr_ena = 1;
    wr_addr = 3;
    wr_data = 32'h33333333;
    step();
    rst = 0;
    wr_ena = 0;
    check("rst_busy", 32'(busy), 0);
    rd("rst_x20", 20, 0);
    rd("rst_x3", 3, 0);
    rd("rst_x31", 31, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
